// File: rtl/ifmap_stream_writer.sv
// ifmap_stream_writer
// Copies a 2-D block of words from a scratch memory into the IFMap circular
// buffer, one word at a time, and tags each word with start-of-row and
// end-of-row bits.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   Start            one-cycle transfer request, honoured only when idle
//   base_addr        address of the first word of row 0
//   row_stride       address step between the first words of adjacent rows
//   row_len          words per row
//   num_rows         number of rows
//   mem_ren/mem_addr scratch-memory read port (data returns one cycle later)
//   mem_rdata        scratch-memory read data
//   ready            IFMap buffer not-full
//   write_en/dout    IFMap buffer write port, dout = {sor, eor, data}
//   busy             high whenever a transfer is in progress
//   done             one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for Start
// READ  | read request on the memory port
// LOAD  | read data captured into dout with its row tags
// PUSH  | write_en held until the buffer accepts the word
// FIN   | done pulse, back to IDLE next cycle
module ifmap_stream_writer #(
   parameter int DATA_WIDTH = 20,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] row_stride,
   input  logic [LEN_WIDTH-1:0]  row_len,
   input  logic [LEN_WIDTH-1:0]  num_rows,
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  ready,
   output logic                  write_en,
   output logic [DATA_WIDTH+1:0] dout,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {IDLE, READ, LOAD, PUSH, FIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] stride_r;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [LEN_WIDTH-1:0]  len_r;
   logic [LEN_WIDTH-1:0]  rows_r;
   logic [LEN_WIDTH-1:0]  col;
   logic [LEN_WIDTH-1:0]  row;

   logic [LEN_WIDTH-1:0]  col_next;
   logic [ADDR_WIDTH-1:0] next_row_base;
   logic                  last_col;
   logic                  last_row;

   assign col_next      = col + LEN_WIDTH'(1);
   assign next_row_base = row_base + stride_r;
   assign last_col      = (col == len_r - LEN_WIDTH'(1));
   assign last_row      = (row == rows_r - LEN_WIDTH'(1));

   // dout doubles as the word register: it is loaded once in LOAD and then
   // held untouched for however long PUSH waits on ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         stride_r <= '0;
         row_base <= '0;
         len_r    <= '0;
         rows_r   <= '0;
         col      <= '0;
         row      <= '0;
         mem_ren  <= 1'b0;
         mem_addr <= '0;
         write_en <= 1'b0;
         dout     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  stride_r <= row_stride;
                  len_r    <= row_len;
                  rows_r   <= num_rows;
                  row_base <= base_addr;
                  col      <= '0;
                  row      <= '0;
                  busy     <= 1'b1;
                  if (row_len == '0 || num_rows == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state    <= READ;
                     mem_ren  <= 1'b1;
                     mem_addr <= base_addr;
                  end
               end
            end
            READ: begin
               mem_ren <= 1'b0;
               state   <= LOAD;
            end
            LOAD: begin
               dout     <= {(col == '0), last_col, mem_rdata};
               write_en <= 1'b1;
               state    <= PUSH;
            end
            PUSH: begin
               if (ready) begin
                  write_en <= 1'b0;
                  if (!last_col) begin
                     col      <= col_next;
                     mem_addr <= row_base + ADDR_WIDTH'(col_next);
                     mem_ren  <= 1'b1;
                     state    <= READ;
                  end else if (!last_row) begin
                     col      <= '0;
                     row      <= row + LEN_WIDTH'(1);
                     row_base <= next_row_base;
                     mem_addr <= next_row_base;
                     mem_ren  <= 1'b1;
                     state    <= READ;
                  end else begin
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
